// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N_REQ valid/ready producers share one FIFO
// write port. A grant lasts up to MAX_BURST beats; on release the next
// winner is picked on the same edge so back-to-back grants have no bubble.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [N_REQ*DATA_W-1:0]   i_req_data,
  output logic [N_REQ-1:0]          o_req_ready,
  input  logic                      i_fifo_full,
  output logic                      o_fifo_wr_en,
  output logic [DATA_W-1:0]         o_fifo_din,
  output logic                      o_grant_valid,
  output logic [$clog2(N_REQ)-1:0]  o_grant_id
);
  localparam int IDW   = $clog2(N_REQ);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [0:0] {S_IDLE, S_GRANT} state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_grant_id;
  logic [IDW-1:0]   r_last_id;
  logic [CNT_W-1:0] r_beat_cnt;

  logic                         w_gv;
  logic [N_REQ-1:0]             w_sel;
  logic [N_REQ-1:0][DATA_W-1:0] w_lane_din;
  logic                         w_beat;
  logic                         w_beat_last;
  logic                         w_release;
  logic [IDW:0]                 w_arb_idle;
  logic [IDW:0]                 w_arb_rel;

  // Round-robin pick: first valid index after 'base' (wrapping), so 'base'
  // itself is considered last. Returns {found, index}.
  function automatic logic [IDW:0] f_arb(input logic [IDW-1:0] base,
                                         input logic [N_REQ-1:0] v);
    logic [IDW:0] res;
    int           idx;
    res = '0;
    // Descending scan so the nearest candidate overwrites farther ones.
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(base) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (v[idx[IDW-1:0]]) res = {1'b1, idx[IDW-1:0]};
    end
    return res;
  endfunction

  assign w_gv          = (r_state == S_GRANT);
  assign o_grant_valid = w_gv;
  assign o_grant_id    = r_grant_id;

  // Per-requester ready and data gating; ready never looks at req_valid.
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign w_sel[i]       = w_gv && (r_grant_id == IDW'(i));
    assign o_req_ready[i] = w_sel[i] && !i_fifo_full;
    assign w_lane_din[i]  = w_sel[i] ? i_req_data[i*DATA_W +: DATA_W] : '0;
  end

  // One-hot select, so OR-ing the gated lanes forms the write-data mux.
  always_comb begin
    o_fifo_din = '0;
    for (int i = 0; i < N_REQ; i++) o_fifo_din = o_fifo_din | w_lane_din[i];
  end

  assign w_beat       = |(i_req_valid & o_req_ready);
  assign o_fifo_wr_en = w_beat;
  assign w_beat_last  = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
  // Grant ends on the last allowed beat or when the owner drops valid;
  // a full stall with valid held is not a release.
  assign w_release    = (w_beat && w_beat_last) || !i_req_valid[r_grant_id];
  assign w_arb_idle   = f_arb(r_last_id, i_req_valid);
  assign w_arb_rel    = f_arb(r_grant_id, i_req_valid);

  // Grant FSM: idle arbitration, burst counting, same-edge re-arbitration.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_grant_id <= '0;
      r_last_id  <= IDW'(N_REQ - 1);
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_arb_idle[IDW]) begin
            r_state    <= S_GRANT;
            r_grant_id <= w_arb_idle[IDW-1:0];
            r_beat_cnt <= '0;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_last_id  <= r_grant_id;
            r_beat_cnt <= '0;
            if (w_arb_rel[IDW]) r_grant_id <= w_arb_rel[IDW-1:0];
            else                r_state    <= S_IDLE;
          end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  a_ready_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
    $onehot0(o_req_ready));
  a_no_write_full: assert property (@(posedge i_clk) disable iff (i_rst)
    o_fifo_wr_en |-> !i_fifo_full);
  a_cnt_range: assert property (@(posedge i_clk) disable iff (i_rst)
    int'(r_beat_cnt) < MAX_BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: table vectors, directed sequences and a
// randomized run checked against a grant-ownership model and FIFO scoreboard.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   valid;
  logic [N*W-1:0] data;
  logic [N-1:0]   ready;
  logic           full;
  logic           wr_en;
  logic [W-1:0]   din;
  logic           gv;
  logic [1:0]     gid;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .i_req_data(data),
    .o_req_ready(ready), .i_fifo_full(full), .o_fifo_wr_en(wr_en),
    .o_fifo_din(din), .o_grant_valid(gv), .o_grant_id(gid));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int seq[N];
  logic [W-1:0] base[N];
  logic [W-1:0] fifo_q[$];
  int m_own, m_last, m_cnt;
  int wait_b[N];
  int max_wait;
  logic [N-1:0] s_ready;
  logic s_wr, s_gv;
  logic [1:0] s_gid;

  // Producers offer base + sequence number; sequence advances on handshake.
  always_comb begin
    data = '0;
    for (int i = 0; i < N; i++) data[i*W +: W] = base[i] + W'(seq[i]);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; valid = '0; full = 1'b0;
    for (int i = 0; i < N; i++) begin seq[i] = 0; wait_b[i] = 0; end
    fifo_q.delete();
    #1;
    chk("rst_ready", ready, 0); chk("rst_wr", wr_en, 0); chk("rst_din", din, 0);
    chk("rst_gv", gv, 0);       chk("rst_gid", gid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_own = -1; m_last = N - 1; m_cnt = 0;
  endtask

  // One clock: drive, compare against model at negedge, advance model.
  task automatic cyc(input logic [N-1:0] v, input logic f);
    logic [N-1:0] bt, er;
    logic b;
    valid = v; full = f;
    @(negedge clk);
    er = (m_own >= 0 && !f) ? N'(1 << m_own) : '0;
    chk("ready", ready, er);
    chk("wr_en", wr_en, (m_own >= 0) && v[m_own] && !f);
    chk("din", din, (m_own >= 0) ? base[m_own] + W'(seq[m_own]) : '0);
    chk("gvalid", gv, m_own >= 0);
    if (m_own >= 0) chk("gid", gid, m_own);
    s_ready = ready; s_wr = wr_en; s_gv = gv; s_gid = gid;
    if (wr_en) fifo_q.push_back(din);
    bt = valid & ready;
    for (int i = 0; i < N; i++) begin
      if (v[i] && !bt[i]) begin
        if (|(bt & ~(N'(1) << i))) wait_b[i]++;
        if (wait_b[i] > max_wait) max_wait = wait_b[i];
      end else wait_b[i] = 0;
    end
    @(posedge clk); #1;
    if (m_own < 0) begin
      m_own = pick(m_last, v); m_cnt = 0;
    end else begin
      b = v[m_own] && !f;
      if (!v[m_own] || (b && m_cnt == MB - 1)) begin
        m_last = m_own; m_own = pick(m_last, v); m_cnt = 0;
      end else if (b) m_cnt++;
    end
    for (int i = 0; i < N; i++) if (bt[i]) seq[i]++;
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] v;
    logic         f;
    logic [N-1:0] ready;
    logic         wr;
    logic         gv;
    logic [1:0]   gid;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl[NV];

  initial begin
    int wcnt, first_rdy;
    rst = 1'b1; valid = '0; full = 1'b0; max_wait = 0;
    for (int i = 0; i < N; i++) begin base[i] = W'(i << 12); seq[i] = 0; end

    // Requester 2 stalled by full mid-burst, then rotation to 3;
    // requester 1 drops valid, 3 served, then 1 again.
    tbl[0]  = '{1, 4'b0000, 0, 4'b0000, 0, 0, 0};
    tbl[1]  = '{0, 4'b1100, 0, 4'b0000, 0, 0, 0};
    tbl[2]  = '{0, 4'b1100, 0, 4'b0100, 1, 1, 2};
    tbl[3]  = '{0, 4'b1100, 0, 4'b0100, 1, 1, 2};
    for (int k = 4; k < 9; k++) tbl[k] = '{0, 4'b1100, 1, 4'b0000, 0, 1, 2};
    tbl[9]  = '{0, 4'b1100, 0, 4'b0100, 1, 1, 2};
    tbl[10] = '{0, 4'b1100, 0, 4'b0100, 1, 1, 2};
    tbl[11] = '{0, 4'b1100, 0, 4'b1000, 1, 1, 3};
    tbl[12] = '{1, 4'b0000, 0, 4'b0000, 0, 0, 0};
    tbl[13] = '{0, 4'b0010, 0, 4'b0000, 0, 0, 0};
    tbl[14] = '{0, 4'b1010, 0, 4'b0010, 1, 1, 1};
    tbl[15] = '{0, 4'b1000, 0, 4'b0010, 0, 1, 1};
    for (int k = 16; k < 20; k++) tbl[k] = '{0, 4'b1010, 0, 4'b1000, 1, 1, 3};
    tbl[20] = '{0, 4'b1010, 0, 4'b0010, 1, 1, 1};

    // Single requester: 1-cycle ready latency, 4+2 burst with no gap.
    do_reset();
    base[0] = 16'h0100;
    wcnt = 0; first_rdy = -1;
    for (int c = 0; c < 9; c++) begin
      cyc((seq[0] < 6) ? 4'b0001 : 4'b0000, 1'b0);
      if (s_ready[0] && first_rdy < 0) first_rdy = c;
      if (c >= 1 && c <= 6 && s_wr) wcnt++;
    end
    chk("t1_ready_latency", first_rdy, 1);
    chk("t1_contiguous_writes", wcnt, 6);
    chk("t1_fifo_size", fifo_q.size(), 6);
    for (int k = 0; k < 6 && k < fifo_q.size(); k++)
      chk("t1_fifo_word", fifo_q[k], 16'h0100 + W'(k));
    base[0] = 16'h0000;

    // All four continuously valid: 4-beat grants in order 0,1,2,3,0.
    do_reset();
    wcnt = 0;
    for (int c = 0; c < 18; c++) begin
      cyc(4'b1111, 1'b0);
      if (c >= 1 && c <= 16 && s_wr) wcnt++;
      if (c % 4 == 1) chk("t2_gid_seq", s_gid, ((c - 1) / 4) % 4);
    end
    chk("t2_no_idle", wcnt, 16);
    for (int k = 0; k < 16 && k < fifo_q.size(); k++)
      chk("t2_fifo_word", fifo_q[k], W'(((k / 4) << 12) | (k % 4)));

    // Table vectors.
    for (int r = 0; r < NV; r++) begin
      if (tbl[r].rst) do_reset();
      else begin
        cyc(tbl[r].v, tbl[r].f);
        chk($sformatf("tbl%0d_ready", r), s_ready, tbl[r].ready);
        chk($sformatf("tbl%0d_wr", r), s_wr, tbl[r].wr);
        chk($sformatf("tbl%0d_gv", r), s_gv, tbl[r].gv);
        chk($sformatf("tbl%0d_gid", r), s_gid, tbl[r].gid);
      end
    end

    // Async reset mid-burst drops outputs at once; requester 0 wins after.
    do_reset();
    cyc(4'b0001, 1'b0);
    cyc(4'b0001, 1'b0);
    valid = 4'b0001; full = 1'b0;
    #1;
    chk("t5_wr_before_rst", wr_en, 1);
    rst = 1'b1;
    #1;
    chk("t5_ready_async", ready, 0);
    chk("t5_wr_async", wr_en, 0);
    chk("t5_gv_async", gv, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_own = -1; m_last = N - 1; m_cnt = 0;
    cyc(4'b0101, 1'b0);
    cyc(4'b0101, 1'b0);
    chk("t5_first_grant", s_gid, 0);
    chk("t5_first_gv", s_gv, 1);

    // Randomized traffic against the model and per-requester scoreboard.
    do_reset();
    max_wait = 0;
    for (int c = 0; c < 2000; c++) begin
      logic [N-1:0] rv;
      for (int i = 0; i < N; i++) rv[i] = ($urandom_range(0, 3) != 0);
      cyc(rv, $urandom_range(0, 4) == 0);
    end
    begin
      int idx[N];
      for (int i = 0; i < N; i++) idx[i] = 0;
      foreach (fifo_q[k]) begin
        int t;
        t = int'(fifo_q[k][15:12]);
        if (t >= N) chk("rand_tag", t, 0);
        else begin
          chk("rand_order", fifo_q[k], base[t] + W'(idx[t]));
          idx[t]++;
        end
      end
      for (int i = 0; i < N; i++) chk($sformatf("rand_count%0d", i), idx[i], seq[i]);
    end
    chk("rand_fairness", max_wait <= (N - 1) * MB, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter sharing one sync_fifo write port between N_REQ producers.
- Each producer uses a valid/ready interface.
- The arbiter drives the FIFO's wr_en/din and honours its full flag.
- A granted producer may write up to MAX_BURST consecutive words before the grant rotates, so a single source cannot monopolise the FIFO.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 16, data width; must match the FIFO width.
- MAX_BURST, 4, maximum beats per grant (>=1).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  N_REQ  per-requester data valid.
- req_data  in  N_REQ*DATA_W  requester i data occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  per-requester ready; at most one bit is set.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_din  out  DATA_W  FIFO write data.
- grant_valid  out  1  a grant is currently held (state GRANT).
- grant_id  out  $clog2(N_REQ)  index of the granted requester.

Behaviour:
- **Reset** (async, immediate), while rst=1:
  - state=IDLE, grant_id=0, last_id=N_REQ-1 (requester 0 wins the first arbitration), beat_cnt=0.
  - All outputs 0: req_ready=0, fifo_wr_en=0, fifo_din=0, grant_valid=0.
  - Asserting rst mid-burst drops ready/wr_en in the same cycle, with no partial write on the next edge.
- **Transfer**: beat = req_valid[g] && req_ready[g], with g = grant_id.
- **Combinational outputs**:
  - req_ready[g] = grant_valid && !fifo_full; all other bits are 0.
  - fifo_wr_en = beat.
  - fifo_din = req_data slice g when grant_valid, else 0.
  - There is no combinational path from req_valid to req_ready.
- **Arbitration function**: scan indices last_id+1, last_id+2, ... modulo N_REQ; the first index with req_valid=1 wins.
- **FSM, IDLE**:
  - If any req_valid=1: next state GRANT, grant_id=winner, beat_cnt=0.
  - Latency from req_valid to first req_ready is 1 cycle.
  - Otherwise remain in IDLE.
- **FSM, GRANT**:
  - beat and beat_cnt < MAX_BURST-1: beat_cnt++, stay.
  - beat and beat_cnt == MAX_BURST-1: release.
  - req_valid[g]=0: release. A requester dropping valid ends its grant.
  - req_valid[g]=1 and fifo_full=1: stall. State, grant_id and beat_cnt are held. There is no timeout.
- **Release, on the same edge**:
  - last_id := g.
  - Re-arbitrate using the new last_id. The current requester is eligible only if it is still valid and no other requester is valid.
  - If there is a winner: stay in GRANT with the new grant_id and beat_cnt=0. There are no bubble cycles between back-to-back grants.
  - If there is no winner: go to IDLE.
- **Full boundary**:
  - A write is never issued while fifo_full=1.
  - When full deasserts, writing resumes in that same cycle for the held grant.
- **Data integrity**:
  - Words from one requester reach the FIFO in that requester's order.
  - No word is duplicated or lost.
  - Interleaving across requesters is only at grant boundaries.
- **MAX_BURST=1**: rotate after every beat, giving pure per-word round-robin.
- **Single requester continuously valid**: it is re-granted after every burst. Release and re-grant happen on the same edge, so the stream is continuous.
- **Assertions**:
  - $onehot0(req_ready).
  - fifo_wr_en implies !fifo_full.
  - beat_cnt < MAX_BURST.

Test Plan:
1. After reset, req_valid=4'b0001 with data 0x0100..0x0105 and FIFO empty:
   - ready rises one cycle after valid.
   - Bursts of 4 then 2 reach the FIFO continuously, with the same-edge re-grant.
   - The FIFO holds 0x0100..0x0105 in order.
2. All four requesters continuously valid, MAX_BURST=4, data tagged 0xi0nn:
   - grant_id sequence 0,1,2,3,0.
   - Exactly 4 beats per grant, no idle cycles.
   - The FIFO sees 0x0000-0x0003, 0x1000-0x1003, and so on.
3. Requester 2 granted and fifo_full forced high for 5 cycles mid-burst after 2 beats:
   - fifo_wr_en=0 and req_ready=0 during the stall; grant_id stays 2.
   - On full release the remaining 2 beats complete, then the grant rotates to 3.
4. Requester 1 drops valid after 1 beat while requester 3 is valid:
   - Release on that edge; grant_id=3 the next cycle.
   - Requester 1 re-requesting is served only after 3 (round-robin order preserved).
5. Assert rst while mid-burst on requester 0 with wr_en=1:
   - req_ready, fifo_wr_en and grant_valid go to 0 immediately.
   - After rst deasserts with requesters 0 and 2 valid, requester 0 is granted first (last_id=3).
6. Randomised valid/data and full, 2000 cycles, against a scoreboard of per-requester queues vs a FIFO-content model:
   - No loss or duplication.
   - Assertions hold.
   - No requester waits more than (N_REQ-1)*MAX_BURST beats of other requesters.
